mix_columns_engine: RTL and testbench

- Parametrised successor to the single-column mix unit: applies AES MixColumns, InvMixColumns or pass-through to a full 128-bit state.
- Processes NUM_COLS columns per cycle through a 2-stage column pipeline, iterating 4/NUM_COLS beats per state.
- Sits between ShiftRows and AddRoundKey in the round datapath, with valid/ready handshakes on both sides.

---
 rtl/mix_columns_engine.sv | 180 ++++++++++++++++++
 tb/tb_mix_columns_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns / bypass over a 128-bit state. NUM_COLS columns per beat
// flow through a two-stage column pipeline, with valid/ready handshakes on both sides.
module mix_columns_engine #(
  parameter int NUM_COLS = 1,
  parameter int INV_EN   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  localparam int BEATS = (NUM_COLS > 0) ? (4 / NUM_COLS) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = NUM_COLS * 32;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  generate
    if (NUM_COLS != 1 && NUM_COLS != 2 && NUM_COLS != 4) begin : g_bad_cols
      $error("mix_columns_engine: NUM_COLS must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {t, v}: v is the (optionally inverse pre-mixed) column, t_r = 3*v_r ^ v_(r+2).
  function automatic logic [63:0] mix_pre(input logic [31:0] c, input logic inv);
    logic [7:0]  b [4];
    logic [7:0]  v [4];
    logic [7:0]  p02;
    logic [7:0]  p13;
    logic [31:0] vv;
    logic [31:0] tt;
    for (int r = 0; r < 4; r++) b[r] = c[8*r +: 8];
    p02 = inv ? xtime(xtime(b[0] ^ b[2])) : 8'h00;
    p13 = inv ? xtime(xtime(b[1] ^ b[3])) : 8'h00;
    v[0] = b[0] ^ p02;
    v[1] = b[1] ^ p13;
    v[2] = b[2] ^ p02;
    v[3] = b[3] ^ p13;
    for (int r = 0; r < 4; r++) begin
      vv[8*r +: 8] = v[r];
      tt[8*r +: 8] = xtime(v[r]) ^ v[r] ^ v[(r + 2) % 4];
    end
    return {tt, vv};
  endfunction

  function automatic logic [31:0] mix_post(input logic [31:0] v, input logic [31:0] t);
    logic [31:0] o;
    for (int r = 0; r < 4; r++) begin
      o[8*r +: 8] = v[8*r +: 8] ^ t[8*r +: 8] ^ t[8*((r + 1) % 4) +: 8];
    end
    return o;
  endfunction

  logic [1:0]     state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           out_valid_q, out_valid_d;
  logic           accept;
  logic [127:0]   st_q;
  logic [1:0]     mode_q;

  logic           inv_p0, byp_p0;
  logic [LW-1:0]  v_p0, t_p0;

  logic           vld_p1_q, last_p1_q, byp_p1_q;
  logic [BW-1:0]  slot_p1_q;
  logic [LW-1:0]  v_p1_q, t_p1_q, res_p1;

  logic           last_p2_q;
  logic [127:0]   out_state_q;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = DRAIN;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DRAIN: begin
        if (last_p2_q) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
      end
      default: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      vld_p1_q    <= (state_q == RUN);
      last_p1_q   <= (state_q == RUN) && (beat_q == LAST_BEAT);
    end
  end

  // Stage 0 -> 1: select this beat's columns from the latched state and form partial terms.
  assign inv_p0 = (INV_EN != 0) && (mode_q == 2'b01);
  assign byp_p0 = mode_q[1] || (mode_q[0] && !inv_p0);

  always_comb begin
    v_p0 = '0;
    t_p0 = '0;
    for (int j = 0; j < NUM_COLS; j++) begin
      {t_p0[32*j +: 32], v_p0[32*j +: 32]} =
        mix_pre(st_q[int'(beat_q)*LW + 32*j +: 32], inv_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      st_q   <= in_state;
      mode_q <= in_mode;
    end
    v_p1_q    <= v_p0;
    t_p1_q    <= t_p0;
    byp_p1_q  <= byp_p0;
    slot_p1_q <= beat_q;
  end

  // Stage 1 -> 2: finish each column and drop it into its slot of the output state.
  always_comb begin
    res_p1 = '0;
    for (int j = 0; j < NUM_COLS; j++) begin
      res_p1[32*j +: 32] = byp_p1_q ? v_p1_q[32*j +: 32]
                                    : mix_post(v_p1_q[32*j +: 32], t_p1_q[32*j +: 32]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q <= '0;
      last_p2_q   <= 1'b0;
    end else begin
      last_p2_q <= vld_p1_q && last_p1_q;
      if (vld_p1_q) out_state_q[int'(slot_p1_q)*LW +: LW] <= res_p1;
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: one instance per legal NUM_COLS, directed vectors,
// backpressure and mid-run reset sequences, and a random regression against an AES model.
module tb_mix_columns_engine;
  localparam logic [127:0] F_IN  = 128'hC6C6C6C6_01010101_5C220AF2_455313DB;
  localparam logic [127:0] F_OUT = 128'hC6C6C6C6_01010101_9D58DC9F_BCA14D8E;
  localparam logic [127:0] R_ST  = 128'h3243F6A8_885A308D_313198A2_E0370734;

  typedef struct {
    int           inst;
    logic [127:0] st;
    logic [1:0]   md;
    logic [127:0] exp;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] ist  [3];
  logic [127:0] ost  [3];
  logic [1:0]   imd  [3];
  int           n_cmp;
  int           n_bad;
  vec_t         tbl  [10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mix_columns_engine #(.NUM_COLS(1), .INV_EN(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(ist[0]),
    .in_mode(imd[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]));
  mix_columns_engine #(.NUM_COLS(2), .INV_EN(1)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(ist[1]),
    .in_mode(imd[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]));
  mix_columns_engine #(.NUM_COLS(4), .INV_EN(1)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(ist[2]),
    .in_mode(imd[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]));

  function automatic int beats_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Straight circulant-matrix AES reference: rows 02 03 01 01 or 0e 0b 0d 09.
  function automatic logic [127:0] aes_mix(input logic [127:0] s, input logic [1:0] md);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (md[1]) return s;
    if (md[0]) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[(k - row + 4) % 4], s[32*c + 8*k +: 8]);
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One full transaction on instance i; hold = cycles of out_ready=0 in HOLD,
  // bp = also drive junk input and check output stability while held.
  task automatic send(input int i, input logic [127:0] st, input logic [1:0] md,
                      input logic [127:0] exp, input int hold, input bit bp, input string nm);
    int n;
    logic [127:0] snap;
    n = 0;
    while (!ir[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, " in_ready idle"}, 128'(ir[i]), 128'd1);
    if (!ir[i]) return;
    iv[i] = 1'b1; ist[i] = st; imd[i] = md; ordy[i] = 1'b0;
    @(negedge clk);
    iv[i] = bp; ist[i] = ~st; imd[i] = ~md;
    n = 0;
    while (!ov[i] && n < 40) begin
      @(negedge clk);
      n++;
      if (bp) ist[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    check({nm, " latency"}, 128'(n), 128'(beats_of(i) + 2));
    check({nm, " data"}, ost[i], exp);
    if (!ov[i]) begin
      iv[i] = 1'b0;
      return;
    end
    snap = ost[i];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (bp) begin
        check({nm, " held data"}, ost[i], snap);
        check({nm, " held valid/ready"}, 128'({ov[i], ir[i]}), 128'b10);
      end
    end
    iv[i] = 1'b0;
    ordy[i] = 1'b1;
    @(negedge clk);
    ordy[i] = 1'b0;
    check({nm, " after handshake valid/ready"}, 128'({ov[i], ir[i]}), 128'b01);
  endtask

  initial begin
    int           ii;
    int           seen;
    logic [127:0] rs;
    logic [1:0]   rm;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; ist[i] = '0; imd[i] = 2'b00;
    end
    rst_n = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset ready/valid %0d", i), 128'({ir[i], ov[i]}), 128'b10);
      check($sformatf("reset out_state %0d", i), ost[i], 128'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0] = '{2, F_IN,  2'b00, F_OUT};
    tbl[1] = '{2, F_OUT, 2'b01, F_IN};
    tbl[2] = '{0, F_IN,  2'b00, F_OUT};
    tbl[3] = '{0, F_OUT, 2'b01, F_IN};
    tbl[4] = '{1, F_IN,  2'b00, F_OUT};
    tbl[5] = '{1, F_OUT, 2'b01, F_IN};
    tbl[6] = '{2, R_ST,  2'b10, R_ST};
    tbl[7] = '{2, R_ST,  2'b11, R_ST};
    tbl[8] = '{0, R_ST,  2'b10, R_ST};
    tbl[9] = '{1, R_ST,  2'b11, R_ST};
    for (int v = 0; v < 10; v++) begin
      send(tbl[v].inst, tbl[v].st, tbl[v].md, tbl[v].exp, 1, 1'b0, $sformatf("vec%0d", v));
    end

    send(2, F_IN, 2'b00, F_OUT, 10, 1'b1, "backpressure c4");
    send(0, F_OUT, 2'b01, F_IN, 10, 1'b1, "backpressure c1");

    // Reset while NUM_COLS=1 instance is issuing beat 2.
    iv[0] = 1'b1; ist[0] = F_IN; imd[0] = 2'b00;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy before reset", 128'(ir[0]), 128'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset ready/valid", 128'({ir[0], ov[0]}), 128'b10);
    check("async reset out_state", ost[0], 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    check("no partial result after reset", 128'(seen), 128'd0);
    send(0, R_ST, 2'b00, aes_mix(R_ST, 2'b00), 1, 1'b0, "post-reset");

    for (int t = 0; t < 1000; t++) begin
      ii = t % 3;
      rs = {$urandom, $urandom, $urandom, $urandom};
      rm = 2'($urandom_range(0, 3));
      send(ii, rs, rm, aes_mix(rs, rm), $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
